mmio_joypad_m: RTL and testbench

Memory-mapped joypad controller for the JOYP register at 0xFF00. It synchronises and debounces the eight raw PMOD button lines (`je`) and presents them through the DMG select-matrix read-back. It also raises the joypad interrupt request that feeds `interrupts.joypad` on `mmio_interrupts_m`. It is a bus slave behind `mmu_m`, alongside `mmio_timer_m`, and replaces the current tie-low of `interrupts.joypad`.

---
 rtl/mmio_joypad_m_pkg.sv | 30 +++
 rtl/mem_if.sv | 20 ++
 rtl/mmio_joypad_m_debounce.sv | 35 +++
 rtl/mmio_joypad_m.sv | 60 ++++++
 tb/tb_mmio_joypad_m.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_joypad_m_pkg.sv
// Joypad (JOYP, 0xFF00) shared definitions.
// Button bit indices and the DMG select-matrix line function.
package mmio_joypad_m_pkg;

  localparam logic [15:0] JOYP_ADDR = 16'hFF00;

  typedef enum logic [2:0] {
    BTN_RIGHT  = 3'd0,
    BTN_LEFT   = 3'd1,
    BTN_UP     = 3'd2,
    BTN_DOWN   = 3'd3,
    BTN_A      = 3'd4,
    BTN_B      = 3'd5,
    BTN_SELECT = 3'd6,
    BTN_START  = 3'd7
  } joy_btn_e;

  // s is active-low stable state; result is the active-low P13..P10 lines
  function automatic logic [3:0] joyp_lines(
    input logic [1:0] sel,
    input logic [7:0] s
  );
    logic [3:0] d;
    logic [3:0] a;
    d = {s[BTN_DOWN], s[BTN_UP], s[BTN_LEFT], s[BTN_RIGHT]};
    a = {s[BTN_START], s[BTN_SELECT], s[BTN_B], s[BTN_A]};
    return (sel[0] ? 4'hF : d) & (sel[1] ? 4'hF : a);
  endfunction

endpackage

// File: rtl/mem_if.sv
// MMU-to-slave request port.
// Reads return rdata/rvalid one cycle after the request.
interface mem_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rvalid;

  modport master (
    output req, we, addr, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, rvalid
  );
endinterface

// File: rtl/mmio_joypad_m_debounce.sv
// Two-flop synchroniser plus stable-level debouncer for one
// active-low button line.
module debounce_m #(
  parameter int DEBOUNCE_CYCLES = 16384
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b11;
      cnt  <= '0;
      out  <= 1'b1;
    end else begin
      sync <= {sync[0], in};
      // any return to the held level restarts the count
      if (sync[1] == out) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        out <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/mmio_joypad_m.sv
// JOYP register slave: debounced buttons, select matrix read-back
// and falling-line joypad interrupt.
module mmio_joypad_m
  import mmio_joypad_m_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16384
) (
  input  logic       clk,
  input  logic       rst,
  mem_if.slave       bus,
  input  logic [7:0] buttons_n,
  output logic       irq,
  output logic [7:0] pressed
);
  logic [7:0] s;
  logic [1:0] sel;
  logic [3:0] p;
  logic [3:0] p_q;
  logic       hit;
  logic       wr;
  logic       rd;
  logic [5:0] unused_wdata;

  for (genvar i = 0; i < 8; i++) begin : g_db
    debounce_m #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk(clk),
      .rst(rst),
      .in (buttons_n[i]),
      .out(s[i])
    );
  end

  assign hit = bus.req && (bus.addr == JOYP_ADDR);
  assign wr  = hit && bus.we;
  assign rd  = hit && !bus.we;

  assign p       = joyp_lines(sel, s);
  assign pressed = ~s;

  assign unused_wdata = {bus.wdata[7:6], bus.wdata[3:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel        <= 2'b11;
      p_q        <= 4'hF;
      irq        <= 1'b0;
      bus.rdata  <= 8'hFF;
      bus.rvalid <= 1'b0;
    end else begin
      if (wr) sel <= bus.wdata[5:4];
      p_q        <= p;
      // select writes that expose a held button fall here too
      irq        <= |(p_q & ~p);
      bus.rvalid <= rd;
      if (rd) bus.rdata <= {2'b11, sel, p};
    end
  end
endmodule

// File: tb/tb_mmio_joypad_m.sv
// Scoreboard bench for mmio_joypad_m: directed scenarios then
// random buttons/bus traffic against a behavioural model.
module tb_mmio_joypad_m;
  import mmio_joypad_m_pkg::*;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] buttons_n = 8'hFF;
  logic       irq;
  logic [7:0] pressed;

  mem_if bus();

  mmio_joypad_m #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .buttons_n(buttons_n),
    .irq      (irq),
    .pressed  (pressed)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  logic [7:0] m_stable = 8'hFF;
  logic [7:0] m_h1     = 8'hFF;
  logic [7:0] m_h2     = 8'hFF;
  logic [7:0] m_sy;
  int         m_run [8];
  logic [1:0] m_sel    = 2'b11;
  logic [3:0] m_p      = 4'hF;
  logic [3:0] m_p_prev = 4'hF;
  logic       m_irq    = 1'b0;
  logic [7:0] exp_q [$];
  int         irq_cycles [$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // a line is low when any selected group has its button held down
  function automatic logic [3:0] ref_lines(input logic [1:0] sl, input logic [7:0] st);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (!sl[0] && !st[i])     r[i] = 1'b0;
      if (!sl[1] && !st[i + 4]) r[i] = 1'b0;
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // model: a level seen D consecutive synchronised samples becomes stable
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_stable = 8'hFF;
      m_h1 = 8'hFF;
      m_h2 = 8'hFF;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      m_sel = 2'b11;
      m_p = 4'hF;
      m_p_prev = 4'hF;
      m_irq = 1'b0;
      exp_q.delete();
    end else begin
      m_irq = |(m_p_prev & ~m_p);
      if (bus.req && bus.addr == 16'hFF00) begin
        if (!bus.we) exp_q.push_back({2'b11, m_sel, m_p});
        else m_sel = bus.wdata[5:4];
      end
      m_sy = m_h2;
      m_h2 = m_h1;
      m_h1 = buttons_n;
      for (int i = 0; i < 8; i++) begin
        if (m_sy[i] == m_stable[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_stable[i] = m_sy[i];
            m_run[i] = 0;
          end
        end
      end
      m_p_prev = m_p;
      m_p = ref_lines(m_sel, m_stable);
    end
  end

  // monitor
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (bus.rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rvalid_unexpected: got rdata %0h expected no response", bus.rdata);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", {24'd0, bus.rdata}, {24'd0, e});
      end
    end else if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL rvalid_missing: got none expected rdata %0h", exp_q[0]);
      exp_q.delete();
    end
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("pressed", {24'd0, pressed}, {24'd0, ~m_stable});
    if (irq === 1'b1) irq_cycles.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bus_op(input logic we, input logic [15:0] a, input logic [7:0] d);
    bus.req = 1'b1;
    bus.we = we;
    bus.addr = a;
    bus.wdata = d;
    tick(1);
    bus.req = 1'b0;
    bus.we = 1'b0;
  endtask

  task automatic read_chk(input string nm, input logic [7:0] exp);
    bus_op(1'b0, JOYP_ADDR, 8'h00);
    chk(nm, {24'd0, bus.rdata}, {24'd0, exp});
  endtask

  function automatic logic [31:0] irq_delay(input int n0, input int t0);
    return (irq_cycles.size() > n0) ? irq_cycles[n0] - t0 : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int n0;
    int t0;
    logic [15:0] a;
    bus.req = 1'b0;
    bus.we = 1'b0;
    bus.addr = 16'h0000;
    bus.wdata = 8'h00;

    // reset
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("reset_pressed", {24'd0, pressed}, 32'h00);
    read_chk("reset_read", 8'hFF);
    tick(20);
    chk("reset_no_irq", irq_cycles.size(), 0);

    // action group, A held
    bus_op(1'b1, JOYP_ADDR, 8'h10);
    n0 = irq_cycles.size();
    t0 = cyc;
    buttons_n = 8'hEF;
    tick(10);
    read_chk("action_read", 8'hDE);
    chk("action_pressed", {24'd0, pressed}, 32'h10);
    chk("action_irq_count", irq_cycles.size() - n0, 1);
    chk("action_irq_delay", irq_delay(n0, t0), 7);
    buttons_n = 8'hFF;
    tick(10);

    // glitch shorter than the debounce window
    bus_op(1'b1, JOYP_ADDR, 8'h20);
    n0 = irq_cycles.size();
    buttons_n = 8'hF7;
    tick(3);
    buttons_n = 8'hFF;
    tick(10);
    read_chk("glitch_read", 8'hEF);
    chk("glitch_no_irq", irq_cycles.size() - n0, 0);
    chk("glitch_pressed", {24'd0, pressed}, 32'h00);

    // both groups selected
    bus_op(1'b1, JOYP_ADDR, 8'h00);
    buttons_n = 8'hDE;
    tick(10);
    read_chk("both_read", 8'hCC);
    n0 = irq_cycles.size();
    buttons_n = 8'hFF;
    tick(10);
    read_chk("both_release_read", 8'hCF);
    chk("both_release_no_irq", irq_cycles.size() - n0, 0);

    // select change exposes a held Start
    bus_op(1'b1, JOYP_ADDR, 8'h30);
    buttons_n = 8'h7F;
    tick(10);
    n0 = irq_cycles.size();
    t0 = cyc;
    bus_op(1'b1, JOYP_ADDR, 8'h10);
    read_chk("selchg_read", 8'hD7);
    tick(3);
    chk("selchg_irq_count", irq_cycles.size() - n0, 1);
    chk("selchg_irq_delay", irq_delay(n0, t0), 2);
    buttons_n = 8'hFF;
    tick(10);

    // reset in the middle of a debounce
    bus_op(1'b1, JOYP_ADDR, 8'h10);
    buttons_n = 8'hEF;
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("mdr_pressed_in_reset", {24'd0, pressed}, 32'h00);
    rst = 1'b1;
    tick(5);
    chk("mdr_pressed_early", {24'd0, pressed}, 32'h00);
    tick(1);
    chk("mdr_pressed_late", {24'd0, pressed}, 32'h10);
    read_chk("mdr_read", 8'hFF);
    buttons_n = 8'hFF;
    tick(10);

    // random traffic
    for (int it = 0; it < 600; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          buttons_n = buttons_n ^ (8'h01 << $urandom_range(0, 7));
          tick($urandom_range(1, 10));
        end
        3: begin
          buttons_n = 8'($urandom);
          tick($urandom_range(1, 3));
        end
        4: bus_op(1'b1, JOYP_ADDR, 8'($urandom));
        5, 6: bus_op(1'b0, JOYP_ADDR, 8'h00);
        7: begin
          a = 16'($urandom);
          if (a == JOYP_ADDR) a = 16'hFF01;
          bus_op(1'($urandom_range(0, 1)), a, 8'($urandom));
        end
        8: tick($urandom_range(1, 8));
        default: begin
          if ($urandom_range(0, 7) == 0) begin
            rst = 1'b0;
            tick($urandom_range(1, 3));
            rst = 1'b1;
          end else begin
            tick(1);
          end
        end
      endcase
    end

    tick(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
